// File: rtl/spi_link_pkg.sv
// Shared types and default widths for the SPI sample link.
// No logic; imported by the link top.
package spi_link_pkg;

    localparam int SAMPLE_W_DEF    = 8;
    localparam int RESULT_W_DEF    = 8;
    localparam int FIFO_DEPTH_DEF  = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} spi_link_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word; pointers wrap modulo DEPTH (power of 2).
// Head is valid the cycle after a push into an empty FIFO; a push when full is accepted only with a same-cycle pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_pop, do_push;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = head_q;

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        // Head follows the entry behind the popped one, or the incoming word if that is the only one.
        if (do_pop) begin
            if (count_q > (AW+1)'(1)) begin
                head_d = mem_q[rd_ptr_d];
            end else if (do_push) begin
                head_d = push_data;
            end
        end else if (empty && do_push) begin
            head_d = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/spi_sample_link.sv
// Full-duplex SPI slave: samples in to a FIFO, one result out per ss frame; LED_MIRROR_EN adds a led mirror.
// Pin edge to action is SYNC_STAGES+1 clk; FIFO pops on s_valid & s_ready, full FIFO drops words (sticky overflow).
module spi_sample_link
    import spi_link_pkg::*;
#(
    parameter int SAMPLE_W    = SAMPLE_W_DEF,
    parameter int RESULT_W    = RESULT_W_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sck,
    input  logic                sdi,
    input  logic                ss,
    output logic                sdo,
    output logic                s_valid,
    output logic [SAMPLE_W-1:0] s_data,
    input  logic                s_ready,
    input  logic                res_valid,
    input  logic [RESULT_W-1:0] res_data,
    output logic                res_ready,
    output logic                frame_done,
    output logic                overflow,
    output logic [7:0]          led
);

    localparam int CNT_W = $clog2(SAMPLE_W);

    logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, ss_sync_q;
    logic                   sck_s, sdi_s, ss_s;
    logic                   sck_prev_q, ss_prev_q;
    logic                   sck_rise, sck_fall, ss_rise;

    spi_link_state_t        state_q, state_d;
    logic [SAMPLE_W-2:0]    rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
    logic [RESULT_W-2:0]    tx_shift_q, tx_shift_d;
    logic                   sdo_q, sdo_d;
    logic [RESULT_W-1:0]    hold_q, hold_d, start_word;
    logic                   hold_full_q, hold_full_d;
    logic                   frame_done_q, frame_done_d;
    logic                   overflow_q, overflow_d;
    logic [SAMPLE_W-1:0]    rx_word;
    logic                   push;
    logic                   fifo_full, fifo_empty;

    // Synchroniser chains carry no reset so a held-high ss survives a reset.
    always_ff @(posedge clk) begin
        sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
        sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
        ss_sync_q  <= {ss_sync_q[SYNC_STAGES-2:0], ss};
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s && !sck_prev_q;
    assign sck_fall = !sck_s && sck_prev_q;
    assign ss_rise  = ss_s && !ss_prev_q;
    assign rx_word  = {rx_shift_q, sdi_s};

    always_comb begin
        state_d      = state_q;
        rx_shift_d   = rx_shift_q;
        rx_cnt_d     = rx_cnt_q;
        tx_shift_d   = tx_shift_q;
        sdo_d        = sdo_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        frame_done_d = 1'b0;
        push         = 1'b0;
        start_word   = hold_full_q ? hold_q : '0;

        if (res_valid && !hold_full_q) begin
            hold_d      = res_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (ss_rise) begin
                    state_d    = SHIFT;
                    rx_cnt_d   = '0;
                    sdo_d      = start_word[RESULT_W-1];
                    tx_shift_d = start_word[RESULT_W-2:0];
                    if (hold_full_q) begin
                        hold_full_d = 1'b0;
                    end
                end
            end
            SHIFT: begin
                if (!ss_s) begin
                    state_d      = FINISH;
                    frame_done_d = 1'b1;
                    sdo_d        = 1'b0;
                end else begin
                    if (sck_rise) begin
                        rx_shift_d = rx_word[SAMPLE_W-2:0];
                        if (rx_cnt_q == CNT_W'(SAMPLE_W-1)) begin
                            push     = 1'b1;
                            rx_cnt_d = '0;
                        end else begin
                            rx_cnt_d = rx_cnt_q + CNT_W'(1);
                        end
                    end
                    // Zero fill drives sdo low once every result bit has been sent.
                    if (sck_fall) begin
                        sdo_d      = tx_shift_q[RESULT_W-2];
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        overflow_d = overflow_q || (push && fifo_full && !s_ready);
    end

    // ss_prev resets high so a frame cannot start until ss has been seen low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rx_shift_q   <= '0;
            rx_cnt_q     <= '0;
            tx_shift_q   <= '0;
            sdo_q        <= 1'b0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            sck_prev_q   <= 1'b0;
            ss_prev_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            rx_shift_q   <= rx_shift_d;
            rx_cnt_q     <= rx_cnt_d;
            tx_shift_q   <= tx_shift_d;
            sdo_q        <= sdo_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            sck_prev_q   <= sck_s;
            ss_prev_q    <= ss_s;
        end
    end

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_sample_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (rx_word),
        .pop       (s_ready),
        .head      (s_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign sdo        = sdo_q;
    assign s_valid    = !fifo_empty;
    assign res_ready  = !hold_full_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

`ifdef LED_MIRROR_EN
    logic [7:0] led_q, led_d, led_word;

    if (SAMPLE_W >= 8) begin : g_led_hi
        assign led_word = rx_word[SAMPLE_W-1 -: 8];
    end else begin : g_led_zx
        assign led_word = {{(8-SAMPLE_W){1'b0}}, rx_word};
    end

    always_comb begin
        led_d = led_q;
        if (push) begin
            led_d = led_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;
`else
    assign led = 8'h00;
`endif

endmodule

// File: tb/tb_spi_sample_link.sv
// Bench for spi_sample_link: table of SPI frames plus hand sequences for FIFO full, pop+push and mid-frame reset.
module tb_spi_sample_link;

    localparam int H = 80;

    logic       clk = 1'b0;
    logic       reset, sck, sdi, ss, sdo, s_valid, s_ready;
    logic       res_valid, res_ready, frame_done, overflow;
    logic [7:0] s_data, res_data, led;

    int         checks = 0;
    int         errors = 0;
    int         fd_cnt = 0;
    int         pop_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [15:0] tx;
        int          nbits;
        bit          offer;
        logic [7:0]  res;
        logic [15:0] exp_rx;
        logic [7:0]  exp_sample;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    spi_sample_link dut (
        .clk        (clk),
        .reset      (reset),
        .sck        (sck),
        .sdi        (sdi),
        .ss         (ss),
        .sdo        (sdo),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .frame_done (frame_done),
        .overflow   (overflow),
        .led        (led)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every pop the DUT performs is compared against the oldest expected sample.
    always begin
        @(negedge clk);
        #2;
        if (reset === 1'b0) begin
            if (frame_done === 1'b1) fd_cnt++;
            if (s_valid === 1'b1 && s_ready === 1'b1) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got 0x%0h, expected no sample", s_data);
                end else begin
                    check("sb_pop", s_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        #30;
        reset = 1'b0;
        #20;
    endtask

    task automatic sck_bit(input logic b, input bit pop_pulse, output logic r);
        sdi = b;
        #H;
        sck = 1'b1;
        r = sdo;
        if (pop_pulse) begin
            #20;
            s_ready = 1'b1;
            #10;
            s_ready = 1'b0;
            #(H-30);
        end else begin
            #H;
        end
        sck = 1'b0;
    endtask

    task automatic master_frame(input logic [15:0] tx, input int nbits, input bit pop_last,
                                output logic [15:0] rx);
        logic r;
        rx = '0;
        ss = 1'b1;
        #H;
        for (int i = 0; i < nbits; i++) begin
            sck_bit(tx[nbits-1-i], pop_last && (i == nbits-1), r);
            rx = {rx[14:0], r};
        end
        #H;
        ss = 1'b0;
        #H;
    endtask

    task automatic pop_one();
        s_ready = 1'b1;
        #10;
        s_ready = 1'b0;
        #10;
    endtask

    initial begin
        logic [15:0] rx;
        logic        r;
        int          fd0, pops0;

        vecs[0] = '{16'h00A5,  8, 1'b0, 8'h00, 16'h0000, 8'hA5};
        vecs[1] = '{16'h005A,  8, 1'b1, 8'h3C, 16'h003C, 8'h5A};
        vecs[2] = '{16'h00FF,  8, 1'b1, 8'h81, 16'h0081, 8'hFF};
        vecs[3] = '{16'h0000,  8, 1'b0, 8'h00, 16'h0000, 8'h00};
        vecs[4] = '{16'h0B7E, 12, 1'b0, 8'h00, 16'h0000, 8'hB7};
        vecs[5] = '{16'h04D2, 12, 1'b1, 8'hE7, 16'h0E70, 8'h4D};
        vecs[6] = '{16'h0096,  8, 1'b1, 8'hC3, 16'h00C3, 8'h96};

        reset = 1'b1; sck = 1'b0; sdi = 1'b0; ss = 1'b0;
        s_ready = 1'b0; res_valid = 1'b0; res_data = 8'h00;
        #40;
        reset = 1'b0;
        check("rst_sdo", sdo, 0);
        check("rst_s_valid", s_valid, 0);
        check("rst_res_ready", res_ready, 1);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_led", led, 0);
        #20;

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].offer) begin
                res_data = vecs[v].res;
                res_valid = 1'b1;
                check("res_ready_pre", res_ready, 1);
                #10;
                res_valid = 1'b0;
                check("res_ready_held", res_ready, 0);
            end
            fd0 = fd_cnt;
            master_frame(vecs[v].tx, vecs[v].nbits, 1'b0, rx);
            check("sdo_word", rx, vecs[v].exp_rx);
            check("frame_done_pulses", fd_cnt - fd0, 1);
            check("res_ready_post", res_ready, 1);
            check("overflow_clear", overflow, 0);
            check("s_valid_after_frame", s_valid, 1);
            check("s_data_head", s_data, vecs[v].exp_sample);
`ifdef LED_MIRROR_EN
            check("led_mirror", led, vecs[v].exp_sample);
`else
            check("led_tied", led, 0);
`endif
            exp_q.push_back(vecs[v].exp_sample);
            pop_one();
            check("single_push", s_valid, 0);
        end

        // FIFO overflow: 17 words into 16 entries with no pops.
        do_reset();
        check("ovf_after_reset", overflow, 0);
        for (int i = 0; i < 17; i++) begin
            master_frame(16'h0020 + 16'(i), 8, 1'b0, rx);
            if (exp_q.size() < 16) exp_q.push_back(8'h20 + 8'(i));
            if (i == 15) check("ovf_at_16", overflow, 0);
        end
        check("ovf_set", overflow, 1);
        check("full_head", s_data, 8'h20);
`ifdef LED_MIRROR_EN
        check("led_dropped", led, 8'h30);
`endif
        pops0 = pop_cnt;
        s_ready = 1'b1;
        #300;
        s_ready = 1'b0;
        #10;
        check("drain_count_ovf", pop_cnt - pops0, 16);
        check("drain_empty_ovf", s_valid, 0);

        // Full FIFO with a pop in the exact cycle of the push.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            master_frame(16'h0040 + 16'(i), 8, 1'b0, rx);
            exp_q.push_back(8'h40 + 8'(i));
        end
        check("full_no_ovf", overflow, 0);
        master_frame(16'h0077, 8, 1'b1, rx);
        exp_q.push_back(8'h77);
        check("poppush_no_ovf", overflow, 0);
        pops0 = pop_cnt;
        s_ready = 1'b1;
        #300;
        s_ready = 1'b0;
        #10;
        check("drain_count_pp", pop_cnt - pops0, 16);
        check("drain_empty_pp", s_valid, 0);

        // Reset three bits into a frame while ss stays high.
        do_reset();
        ss = 1'b1;
        #H;
        sck_bit(1'b1, 1'b0, r);
        sck_bit(1'b0, 1'b0, r);
        sck_bit(1'b1, 1'b0, r);
        reset = 1'b1;
        #30;
        reset = 1'b0;
        #20;
        check("midrst_sdo", sdo, 0);
        check("midrst_res_ready", res_ready, 1);
        fd0 = fd_cnt;
        for (int i = 0; i < 8; i++) sck_bit(1'b1, 1'b0, r);
        #H;
        check("midrst_no_push", s_valid, 0);
        check("midrst_no_frame", fd_cnt - fd0, 0);
        ss = 1'b0;
        #H;
        master_frame(16'h0081, 8, 1'b0, rx);
        check("midrst_valid", s_valid, 1);
        check("midrst_data", s_data, 8'h81);
`ifdef LED_MIRROR_EN
        check("midrst_led", led, 8'h81);
`else
        check("midrst_led", led, 0);
`endif
        exp_q.push_back(8'h81);
        pop_one();
        check("sb_drained", exp_q.size(), 0);
        check("overflow_final", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
